// File: rtl/fc_ctrl_pkg.sv
// Shared definitions for the pipeline flow controller: state encodings,
// default watchdog limit and wait-counter width.
package fc_ctrl_pkg;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DWAIT  = 2'd1;
    localparam logic [1:0] ST_MDWAIT = 2'd2;
    localparam logic [1:0] ST_TFLUSH = 2'd3;

    localparam int unsigned TIMEOUT_DEF = 64;
    localparam int unsigned WAIT_CNT_W  = 8;

    function automatic logic is_wait_state(input logic [1:0] st);
        return (st == ST_DWAIT) || (st == ST_MDWAIT);
    endfunction

endpackage

// File: rtl/fc_ctrl.sv
// Pipeline flow controller: turns jump/trap/memory-wait/mul-div events into
// per-stage flush and rollback commands, with a wait watchdog and stall counter.
module fc_ctrl
    import fc_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_jump_i,
    input  logic             mem_trap_i,
    input  logic             mem_dreq_i,
    input  logic             mem_dready_i,
    input  logic             ex_md_start_i,
    input  logic             ex_md_done_i,
    output logic             fc_bk_pc_o,
    output logic             fc_bk_ifid_o,
    output logic             fc_bk_idex_o,
    output logic             fc_bk_exmem_o,
    output logic             fc_bk_memwb_o,
    output logic             fc_flush_ifid_o,
    output logic             fc_flush_idex_o,
    output logic             fc_flush_exmem_o,
    output logic             fc_flush_memwb_o,
    output logic             fc_timeout_o,
    output logic [CNT_W-1:0] fc_stall_cnt_o,
    output logic [1:0]       fc_state_o
);

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [WAIT_CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0]      r_stall_cnt;

    logic w_dwait_entry;
    logic w_md_entry;
    logic w_run_clean;
    logic w_waiting;
    logic w_tmo_hit;
    logic w_tflush;

    assign w_dwait_entry = mem_dreq_i & ~mem_dready_i;
    assign w_md_entry    = ex_md_start_i & ~ex_md_done_i;
    assign w_waiting     = is_wait_state(r_state);
    assign w_tflush      = (r_state == ST_TFLUSH);
    assign w_tmo_hit     = (r_wait_cnt == WAIT_CNT_W'(TIMEOUT - 1));
    // Flushes are suppressed on a wait-entry cycle: the instruction is replayed later.
    assign w_run_clean   = (r_state == ST_RUN) & ~w_dwait_entry & ~w_md_entry;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_dwait_entry)
                    w_state_nxt = ST_DWAIT;
                else if (w_md_entry)
                    w_state_nxt = ST_MDWAIT;
            end
            ST_DWAIT: begin
                if (mem_dready_i)
                    w_state_nxt = ST_RUN;
                else if (w_tmo_hit)
                    w_state_nxt = ST_TFLUSH;
            end
            ST_MDWAIT: begin
                if (ex_md_done_i)
                    w_state_nxt = ST_RUN;
                else if (w_tmo_hit)
                    w_state_nxt = ST_TFLUSH;
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_wait_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Clearing outside the wait states is equivalent to clearing on entry.
            if (w_waiting)
                r_wait_cnt <= r_wait_cnt + WAIT_CNT_W'(1);
            else
                r_wait_cnt <= '0;
            if (w_waiting && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign fc_bk_pc_o       = w_waiting;
    assign fc_bk_ifid_o     = w_waiting;
    assign fc_bk_idex_o     = w_waiting;
    assign fc_bk_exmem_o    = w_waiting;
    assign fc_bk_memwb_o    = w_waiting;

    assign fc_flush_ifid_o  = (w_run_clean & (ex_jump_i | mem_trap_i)) | w_tflush;
    assign fc_flush_idex_o  = (w_run_clean & (ex_jump_i | mem_trap_i)) | w_tflush;
    assign fc_flush_exmem_o = (w_run_clean & mem_trap_i) | w_tflush;
    assign fc_flush_memwb_o = w_tflush;

    assign fc_timeout_o     = w_tflush;
    assign fc_stall_cnt_o   = r_stall_cnt;
    assign fc_state_o       = r_state;

endmodule
